// File: rtl/io_wb_master_if.sv
// io_wb_master_if -- bundle of the CPU-side request/response signals and the
// 8-bit Wishbone B4 pipelined bus used by io_wb_master.
//   CPU side : i_req, i_we, i_addr, i_wdata -> o_rdata, o_done, o_err, o_busy
//   Wishbone : o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data (out)
//              i_wb_data, i_wb_ack, i_wb_stall (in)
// The master modport is the initiator's view; slave is the view of
// everything around it (sequencer plus I/O fabric).
interface io_wb_master_if #(
  parameter int ADDR_W = 8
);
  logic              i_req;
  logic              i_we;
  logic [ADDR_W-1:0] i_addr;
  logic [7:0]        i_wdata;
  logic [7:0]        o_rdata;
  logic              o_done;
  logic              o_err;
  logic              o_busy;
  logic              o_wb_cyc;
  logic              o_wb_stb;
  logic              o_wb_we;
  logic [ADDR_W-1:0] o_wb_addr;
  logic [7:0]        o_wb_data;
  logic [7:0]        i_wb_data;
  logic              i_wb_ack;
  logic              i_wb_stall;

  modport master (
    input  i_req, i_we, i_addr, i_wdata, i_wb_data, i_wb_ack, i_wb_stall,
    output o_rdata, o_done, o_err, o_busy,
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data
  );

  modport slave (
    output i_req, i_we, i_addr, i_wdata, i_wb_data, i_wb_ack, i_wb_stall,
    input  o_rdata, o_done, o_err, o_busy,
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data
  );
endinterface

// File: rtl/io_wb_master.sv
// io_wb_master -- single-transaction Wishbone B4 pipelined initiator.
// Converts one CPU I/O port access (IN/OUT) into one 8-bit Wishbone read or
// write, tolerating stall, zero-wait or delayed ack, and aborting with
// o_err=1 (read data 8'hFF, like an empty IMSAI port) when no ack arrives
// within TIMEOUT cycles of the strobe first rising.
// Ports:
//   i_clk   : system clock
//   i_reset : synchronous active-high reset
//   bus     : io_wb_master_if.master (CPU request/response + Wishbone)
// Every output is a register; the FSM is a state register plus a
// combinational next-state/next-output process.
module io_wb_master #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic           i_clk,
  input  logic           i_reset,
  io_wb_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  // Last count value before abort: with the counter at 0 in the first REQ
  // cycle, DONE is entered exactly TIMEOUT cycles after stb rises.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t            state_reg, state_next;
  logic              cyc_reg, cyc_next;
  logic              stb_reg, stb_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [7:0]        wdata_reg, wdata_next;
  logic [7:0]        rdata_reg, rdata_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic              busy_reg, busy_next;
  logic [15:0]       cnt_reg, cnt_next;
  logic              timed_out;

  assign timed_out = (cnt_reg == CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg <= IDLE;
      cyc_reg   <= 1'b0;
      stb_reg   <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= 8'h00;
      rdata_reg <= 8'h00;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      cnt_reg   <= 16'h0000;
    end else begin
      state_reg <= state_next;
      cyc_reg   <= cyc_next;
      stb_reg   <= stb_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
      busy_reg  <= busy_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cyc_next   = cyc_reg;
    stb_next   = stb_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    done_next  = 1'b0;
    err_next   = err_reg;
    busy_next  = busy_reg;
    cnt_next   = cnt_reg;

    case (state_reg)
      IDLE: begin
        if (bus.i_req) begin
          we_next    = bus.i_we;
          addr_next  = bus.i_addr;
          wdata_next = bus.i_wdata;
          cyc_next   = 1'b1;
          stb_next   = 1'b1;
          busy_next  = 1'b1;
          cnt_next   = 16'h0000;
          state_next = REQ;
        end
      end

      REQ, WAIT: begin
        cnt_next = cnt_reg + 16'h0001;
        // An ack only counts for our request once it is no longer stalled;
        // a valid ack takes priority over a simultaneous timeout.
        if (bus.i_wb_ack && (state_reg == WAIT || !bus.i_wb_stall)) begin
          state_next = DONE;
          cyc_next   = 1'b0;
          stb_next   = 1'b0;
          done_next  = 1'b1;
          err_next   = 1'b0;
          if (!we_reg) rdata_next = bus.i_wb_data;
        end else if (timed_out) begin
          state_next = DONE;
          cyc_next   = 1'b0;
          stb_next   = 1'b0;
          done_next  = 1'b1;
          err_next   = 1'b1;
          if (!we_reg) rdata_next = 8'hFF;
        end else if (state_reg == REQ && !bus.i_wb_stall) begin
          // Request accepted without ack: release strobe, keep the cycle.
          stb_next   = 1'b0;
          state_next = WAIT;
        end
      end

      DONE: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        cyc_next   = 1'b0;
        stb_next   = 1'b0;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign bus.o_rdata   = rdata_reg;
  assign bus.o_done    = done_reg;
  assign bus.o_err     = err_reg;
  assign bus.o_busy    = busy_reg;
  assign bus.o_wb_cyc  = cyc_reg;
  assign bus.o_wb_stb  = stb_reg;
  assign bus.o_wb_we   = we_reg;
  assign bus.o_wb_addr = addr_reg;
  assign bus.o_wb_data = wdata_reg;

endmodule

// File: tb/tb_io_wb_master.sv
// tb_io_wb_master -- directed, table-driven bench for io_wb_master
// (ADDR_W=8, TIMEOUT=16). Each table row describes one transaction, the
// slave's stall/ack behaviour for it, and the hand-computed outcome.
module tb_io_wb_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  io_wb_master_if #(.ADDR_W(8)) bus ();

  io_wb_master #(.ADDR_W(8), .TIMEOUT(16)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.master)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // stall_n / ack_dly of 999 mean "forever" / "never".
  // ack_dly counts cycles after the slave accepts stb (0 = ack with it).
  // exp_lat is the cycle of o_done, counting the first cycle after i_req
  // is sampled as 1.
  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         stall_n;
    int         ack_dly;
    logic [7:0] slave_data;
    int         exp_lat;
    int         exp_stb;
    logic [7:0] exp_rdata;
    logic       exp_err;
  } vec_t;

  task automatic run_vec(input int idx, input vec_t v);
    int c, stb_cnt, lat, stall_left, acc_c, unstable;
    logic cyc_at_done, busy_at_done;
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_we = v.we; bus.i_addr = v.addr; bus.i_wdata = v.wdata;
    bus.i_wb_data = v.slave_data;
    @(negedge clk);
    bus.i_req = 1'b0;
    c = 1; stall_left = v.stall_n; acc_c = -1; lat = -1; stb_cnt = 0; unstable = 0;
    cyc_at_done = 1'b1; busy_at_done = 1'b0;
    while (c < 60 && lat < 0) begin
      if (bus.o_done) begin
        lat = c;
        cyc_at_done = bus.o_wb_cyc | bus.o_wb_stb;
        busy_at_done = bus.o_busy;
      end else begin
        if (bus.o_wb_cyc && (bus.o_wb_we !== v.we || bus.o_wb_addr !== v.addr ||
                             bus.o_wb_data !== v.wdata)) unstable++;
        bus.i_wb_ack = 1'b0; bus.i_wb_stall = 1'b0;
        if (bus.o_wb_stb) begin
          stb_cnt++;
          if (stall_left > 0) begin
            bus.i_wb_stall = 1'b1;
            stall_left--;
          end else begin
            acc_c = c;
            if (v.ack_dly == 0) bus.i_wb_ack = 1'b1;
          end
        end else if (acc_c >= 0 && c == acc_c + v.ack_dly) begin
          bus.i_wb_ack = 1'b1;
        end
        @(negedge clk);
        c++;
      end
    end
    bus.i_wb_ack = 1'b0; bus.i_wb_stall = 1'b0;
    check($sformatf("v%0d latency", idx), lat, v.exp_lat);
    check($sformatf("v%0d stb_cycles", idx), stb_cnt, v.exp_stb);
    check($sformatf("v%0d rdata", idx), bus.o_rdata, v.exp_rdata);
    check($sformatf("v%0d err", idx), bus.o_err, v.exp_err);
    check($sformatf("v%0d cyc_stb_at_done", idx), cyc_at_done, 1'b0);
    check($sformatf("v%0d busy_at_done", idx), busy_at_done, 1'b1);
    check($sformatf("v%0d bus_stable", idx), unstable, 0);
    @(negedge clk);
    check($sformatf("v%0d done_one_cycle", idx), bus.o_done, 1'b0);
    check($sformatf("v%0d busy_cleared", idx), bus.o_busy, 1'b0);
    $display("vec %0d: we=%0b addr=%02h lat=%0d stb=%0d rdata=%02h err=%0b",
             idx, v.we, v.addr, lat, stb_cnt, bus.o_rdata, bus.o_err);
  endtask

  vec_t vecs [9];
  int done_cnt, last_done, k, gap_bad;

  initial begin
    // we addr wdata stall ack slave lat stb rdata err
    vecs[0] = '{1'b0, 8'h02, 8'h00, 0,   0,   8'h5A, 2,  1,  8'h5A, 1'b0};
    vecs[1] = '{1'b1, 8'h01, 8'hC3, 3,   0,   8'hEE, 5,  4,  8'h5A, 1'b0};
    vecs[2] = '{1'b0, 8'h10, 8'h00, 0,   4,   8'h11, 6,  1,  8'h11, 1'b0};
    vecs[3] = '{1'b0, 8'h20, 8'h00, 0,   999, 8'h33, 17, 1,  8'hFF, 1'b1};
    vecs[4] = '{1'b0, 8'h03, 8'h00, 0,   0,   8'h77, 2,  1,  8'h77, 1'b0};
    vecs[5] = '{1'b1, 8'h04, 8'h99, 999, 999, 8'h12, 17, 16, 8'h77, 1'b1};
    vecs[6] = '{1'b0, 8'h07, 8'h00, 2,   2,   8'hA5, 6,  3,  8'hA5, 1'b0};
    vecs[7] = '{1'b0, 8'h08, 8'h00, 0,   15,  8'h3C, 17, 1,  8'h3C, 1'b0};
    vecs[8] = '{1'b0, 8'h09, 8'h00, 0,   16,  8'h4D, 17, 1,  8'hFF, 1'b1};

    bus.i_req = 1'b0; bus.i_we = 1'b0; bus.i_addr = 8'h00; bus.i_wdata = 8'h00;
    bus.i_wb_data = 8'h00; bus.i_wb_ack = 1'b0; bus.i_wb_stall = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst cyc", bus.o_wb_cyc, 1'b0);
    check("rst stb", bus.o_wb_stb, 1'b0);
    check("rst busy", bus.o_busy, 1'b0);
    check("rst done", bus.o_done, 1'b0);
    check("rst err", bus.o_err, 1'b0);
    check("rst rdata", bus.o_rdata, 8'h00);
    check("rst wb_bus", {bus.o_wb_we, bus.o_wb_addr, bus.o_wb_data}, 17'h0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Reset while waiting for ack
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_we = 1'b0; bus.i_addr = 8'h05;
    @(negedge clk);
    bus.i_req = 1'b0;
    @(negedge clk);
    check("wait cyc", bus.o_wb_cyc, 1'b1);
    check("wait stb", bus.o_wb_stb, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid cyc_stb", {bus.o_wb_cyc, bus.o_wb_stb}, 2'b00);
    check("rst_mid busy", bus.o_busy, 1'b0);
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.o_done) done_cnt++;
      @(negedge clk);
    end
    check("rst_mid no_done", done_cnt, 0);
    $display("reset in WAIT: dones after reset=%0d", done_cnt);
    begin
      vec_t v;
      v = '{1'b0, 8'h0A, 8'h00, 0, 0, 8'h42, 2, 1, 8'h42, 1'b0};
      run_vec(9, v);
    end

    // Continuous requests against a zero-wait slave
    bus.i_req = 1'b1; bus.i_we = 1'b0; bus.i_addr = 8'h06; bus.i_wb_data = 8'h66;
    done_cnt = 0; last_done = -1; gap_bad = 0;
    for (k = 0; k < 30; k++) begin
      if (bus.o_done) begin
        if (last_done >= 0 && k - last_done != 3) gap_bad++;
        last_done = k;
        done_cnt++;
      end
      bus.i_wb_ack = bus.o_wb_stb;
      @(negedge clk);
    end
    bus.i_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.i_wb_ack = bus.o_wb_stb;
      @(negedge clk);
    end
    bus.i_wb_ack = 1'b0;
    check("b2b gap_errors", gap_bad, 0);
    check("b2b enough_done", done_cnt >= 9, 1'b1);
    check("b2b rdata", bus.o_rdata, 8'h66);
    $display("back-to-back: %0d completions in 30 cycles", done_cnt);

    // Stray acks while idle
    done_cnt = 0; gap_bad = 0;
    repeat (3) @(negedge clk);
    bus.i_wb_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.o_done) done_cnt++;
      if (bus.o_busy || bus.o_wb_cyc) gap_bad++;
    end
    bus.i_wb_ack = 1'b0;
    check("stray no_done", done_cnt, 0);
    check("stray idle", gap_bad, 0);
    $display("stray ack: dones=%0d", done_cnt);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
